// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - Moore control sequencer for fetch and register-register ALU/MUL/DIV instructions
module alu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             run,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             MDRout,
    output logic             Rout,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Rin,
    output logic             LOin,
    output logic             HIin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             IncPC,
    output logic             Read,
    output logic [4:0]       Operator,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    state_t     state, state_nxt;
    logic       retire;
    logic [4:0] opc;
    logic       is_alu, is_muldiv, is_nop, is_halt;

    assign opc       = IR[31:27];
    assign is_alu    = (opc >= 5'd3) && (opc <= 5'd11);
    assign is_muldiv = (opc == 5'd15) || (opc == 5'd16);
    assign is_nop    = (opc == 5'd26);
    assign is_halt   = (opc == 5'd27);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state       <= IDLE;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        MDRout    = 1'b0;
        Rout      = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        Rin       = 1'b0;
        LOin      = 1'b0;
        HIin      = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        Operator  = 5'd0;
        illegal   = 1'b0;
        halted    = 1'b0;
        case (state)
            IDLE: state_nxt = run ? T0 : IDLE;
            T0: begin
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                Zin       = 1'b1;
                state_nxt = T1;
            end
            T1: begin
                Zlowout   = 1'b1;
                PCin      = 1'b1;
                Read      = 1'b1;
                MDRin     = 1'b1;
                state_nxt = T2;
            end
            T2: begin
                MDRout    = 1'b1;
                IRin      = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                if (is_alu || is_muldiv) begin
                    Grb       = 1'b1;
                    Rout      = 1'b1;
                    Yin       = 1'b1;
                    state_nxt = T4;
                end else if (is_halt) begin
                    state_nxt = HALT;
                end else begin
                    // NOP retires here; illegal opcodes fall through without retiring
                    retire    = is_nop;
                    illegal   = !is_nop;
                    state_nxt = run ? T0 : IDLE;
                end
            end
            T4: begin
                Grc       = 1'b1;
                Rout      = 1'b1;
                Zin       = 1'b1;
                Operator  = opc;
                state_nxt = T5;
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin      = 1'b1;
                    state_nxt = T6;
                end else begin
                    Gra       = 1'b1;
                    Rin       = 1'b1;
                    retire    = 1'b1;
                    state_nxt = run ? T0 : IDLE;
                end
            end
            T6: begin
                Zhighout  = 1'b1;
                HIin      = 1'b1;
                retire    = 1'b1;
                state_nxt = run ? T0 : IDLE;
            end
            HALT: halted = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        clear;
    logic        run;
    logic [31:0] IR;
    logic        PCout, Zlowout, Zhighout, MDRout, Rout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin, Rin, LOin, HIin;
    logic        Gra, Grb, Grc, IncPC, Read, illegal, halted;
    logic [4:0]  Operator;
    logic [15:0] instr_count;
    logic [20:0] sig;

    int checks = 0;
    int errors = 0;

    localparam logic [20:0] PCO  = 21'd1 << 20;
    localparam logic [20:0] ZLO  = 21'd1 << 19;
    localparam logic [20:0] ZHO  = 21'd1 << 18;
    localparam logic [20:0] MDRO = 21'd1 << 17;
    localparam logic [20:0] RO   = 21'd1 << 16;
    localparam logic [20:0] MARI = 21'd1 << 15;
    localparam logic [20:0] PCI  = 21'd1 << 14;
    localparam logic [20:0] MDRI = 21'd1 << 13;
    localparam logic [20:0] IRI  = 21'd1 << 12;
    localparam logic [20:0] YI   = 21'd1 << 11;
    localparam logic [20:0] ZI   = 21'd1 << 10;
    localparam logic [20:0] RI   = 21'd1 << 9;
    localparam logic [20:0] LOI  = 21'd1 << 8;
    localparam logic [20:0] HII  = 21'd1 << 7;
    localparam logic [20:0] GA   = 21'd1 << 6;
    localparam logic [20:0] GB   = 21'd1 << 5;
    localparam logic [20:0] GC   = 21'd1 << 4;
    localparam logic [20:0] INC  = 21'd1 << 3;
    localparam logic [20:0] RD   = 21'd1 << 2;
    localparam logic [20:0] ILL  = 21'd1 << 1;
    localparam logic [20:0] HLT  = 21'd1 << 0;

    localparam logic [20:0] S_T0 = PCO | MARI | INC | ZI;
    localparam logic [20:0] S_T1 = ZLO | PCI | RD | MDRI;
    localparam logic [20:0] S_T2 = MDRO | IRI;
    localparam logic [20:0] S_T3 = GB | RO | YI;
    localparam logic [20:0] S_T4 = GC | RO | ZI;

    alu_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .clear(clear), .run(run), .IR(IR),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Rout(Rout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Rin(Rin), .LOin(LOin), .HIin(HIin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .IncPC(IncPC), .Read(Read), .Operator(Operator), .illegal(illegal),
        .halted(halted), .instr_count(instr_count)
    );

    assign sig = {PCout, Zlowout, Zhighout, MDRout, Rout, MARin, PCin, MDRin, IRin,
                  Yin, Zin, Rin, LOin, HIin, Gra, Grb, Grc, IncPC, Read, illegal, halted};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock and check strobes, operator and count at the falling edge
    task automatic step(input string tag, input logic [20:0] es, input logic [4:0] eop,
                        input logic [15:0] ecnt);
        @(negedge clk);
        check({tag, ".sig"}, 32'(sig), 32'(es));
        check({tag, ".op"}, 32'(Operator), 32'(eop));
        check({tag, ".cnt"}, 32'(instr_count), 32'(ecnt));
    endtask

    task automatic fetch_rest(input string tag, input logic [15:0] cnt);
        step({tag, ".T1"}, S_T1, 5'd0, cnt);
        step({tag, ".T2"}, S_T2, 5'd0, cnt);
    endtask

    initial begin
        clear = 1'b0;
        run   = 1'b1;
        IR    = 32'h2292_0000;
        repeat (3) @(negedge clk);
        check("rst.sig", 32'(sig), 32'd0);
        check("rst.op", 32'(Operator), 32'd0);
        check("rst.cnt", 32'(instr_count), 32'd0);

        // SUB R5,R2,R4
        clear = 1'b1;
        step("sub.T0", S_T0, 5'd0, 16'd0);
        fetch_rest("sub", 16'd0);
        step("sub.T3", S_T3, 5'd0, 16'd0);
        step("sub.T4", S_T4, 5'd4, 16'd0);
        step("sub.T5", ZLO | GA | RI, 5'd0, 16'd0);
        step("mul.T0", S_T0, 5'd0, 16'd1);

        // MUL, back-to-back
        IR = 32'h7A92_0000;
        fetch_rest("mul", 16'd1);
        step("mul.T3", S_T3, 5'd0, 16'd1);
        step("mul.T4", S_T4, 5'd15, 16'd1);
        step("mul.T5", ZLO | LOI, 5'd0, 16'd1);
        step("mul.T6", ZHO | HII, 5'd0, 16'd1);
        step("ill.T0", S_T0, 5'd0, 16'd2);

        // illegal opcode 11111
        IR = 32'hF800_0000;
        fetch_rest("ill", 16'd2);
        step("ill.T3", ILL, 5'd0, 16'd2);
        step("nop.T0", S_T0, 5'd0, 16'd2);

        // NOP retires from T3
        IR = 32'hD000_0000;
        fetch_rest("nop", 16'd2);
        step("nop.T3", 21'd0, 5'd0, 16'd2);
        step("add.T0", S_T0, 5'd0, 16'd3);

        // ADD with run dropped during T4
        IR = 32'h1800_0000;
        fetch_rest("add", 16'd3);
        step("add.T3", S_T3, 5'd0, 16'd3);
        step("add.T4", S_T4, 5'd3, 16'd3);
        run = 1'b0;
        step("add.T5", ZLO | GA | RI, 5'd0, 16'd3);
        step("add.idle", 21'd0, 5'd0, 16'd4);
        step("add.idle2", 21'd0, 5'd0, 16'd4);

        // ADD with clear pulsed in T4
        run = 1'b1;
        step("clr.T0", S_T0, 5'd0, 16'd4);
        fetch_rest("clr", 16'd4);
        step("clr.T3", S_T3, 5'd0, 16'd4);
        step("clr.T4", S_T4, 5'd3, 16'd4);
        #1 clear = 1'b0;
        #1;
        check("clr.async.sig", 32'(sig), 32'd0);
        check("clr.async.op", 32'(Operator), 32'd0);
        check("clr.async.cnt", 32'(instr_count), 32'd0);
        @(negedge clk);
        check("clr.held.sig", 32'(sig), 32'd0);
        clear = 1'b1;

        // HALT
        IR = 32'hD800_0000;
        step("hlt.T0", S_T0, 5'd0, 16'd0);
        fetch_rest("hlt", 16'd0);
        step("hlt.T3", 21'd0, 5'd0, 16'd0);
        for (int i = 0; i < 4; i++)
            step("hlt.halt", HLT, 5'd0, 16'd0);
        run = 1'b0;
        step("hlt.norun", HLT, 5'd0, 16'd0);
        clear = 1'b0;
        #1;
        check("hlt.clr.sig", 32'(sig), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        step("hlt.idle", 21'd0, 5'd0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
